burst_memory: RTL and testbench
===============================

BURST_MEMORY -- requirements
Module: burst_memory

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- WIDTH, 16, data width in bits; multiple of 8.
- DEPTH, 512, number of words.
- ADDR_WIDTH, $clog2(DEPTH), address bits.
- LEN_WIDTH, 4, burst length field; max burst = 2^LEN_WIDTH beats.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk_i, in, 1, single clock.
- rst_i, in, 1, reset, asynchronous, active-high.
- valid_i, in, 1, command request.
- ready_o, out, 1, command accept.
- wr_rd_en_i, in, 1, 1=write burst, 0=read burst.
- addr_i, in, ADDR_WIDTH, start address.
- len_i, in, LEN_WIDTH, beats minus one.
- wdata_i, in, WIDTH, write beat data.
- wstrb_i, in, WIDTH/8, byte write enables.
- wvalid_i, in, 1, write beat valid.
- wready_o, out, 1, write beat accept.
- rdata_o, out, WIDTH, read beat data.
- rvalid_o, out, 1, read beat valid.
- rready_i, in, 1, read beat accept.
- rlast_o, out, 1, final read beat.
- done_o, out, 1, write burst complete pulse.
- err_o, out, 1, burst touched an address >= DEPTH.

Function
REQ-003 FSM SHALL have states IDLE, WRITE, READ; all outputs registered.
REQ-004 IDLE: ready_o=1; command accepted on clock edge with valid_i && ready_o; addr_i, len_i, wr_rd_en_i latched; ready_o=0 from next cycle until return to IDLE.
REQ-005 valid_i while ready_o=0 SHALL be ignored; no queuing.
REQ-006 Accept with wr_rd_en_i=1 -> WRITE; wready_o=1 for the whole state.
REQ-007 WRITE: each edge with wvalid_i=1 writes byte lanes with wstrb_i[k]=1 at current address; other lanes unchanged; address +1, beat count -1.
REQ-008 After the (len_i+1)-th write beat: state -> IDLE, wready_o=0, done_o=1 for exactly one cycle, err_o valid in the same cycle.
REQ-009 Accept with wr_rd_en_i=0 -> READ; rvalid_o=1 with first word exactly one cycle after the accept edge.
REQ-010 READ: rdata_o, rlast_o stable while rvalid_o && !rready_i; each edge with rvalid_o && rready_i advances to next word; throughput 1 beat/cycle when rready_i held high.
REQ-011 rlast_o=1 only on beat len_i+1; handshake on that beat -> rvalid_o=0, state -> IDLE; err_o valid with the rlast_o beat.
REQ-012 Address increments modulo 2^ADDR_WIDTH; bursts wrap past the top.
REQ-013 Beats at address >= DEPTH: writes discarded, reads return 0, err_o=1 at burst end; err_o=0 otherwise; err_o cleared when leaving the completion cycle or beat.
REQ-014 wvalid_i outside WRITE and rready_i outside READ SHALL be ignored.
REQ-015 len_i=0 SHALL be a single-beat burst with done_o or rlast_o on that beat.

Reset
REQ-016 rst_i=1 SHALL immediately force IDLE, ready_o=0, wready_o=0, rvalid_o=0, rlast_o=0, done_o=0, err_o=0, rdata_o=0.
REQ-017 ready_o SHALL rise on the first clock edge after rst_i deasserts.
REQ-018 Memory contents SHALL be unaffected by reset; reset mid-burst aborts the burst, and no further beats are written or returned.

Structure
REQ-019 Package burst_memory_pkg SHALL hold the state typedef (IDLE/WRITE/READ) and the opcode constants OP_READ=0, OP_WRITE=1.
REQ-020 Storage SHALL be sub-module burst_memory_array: synchronous read, byte-strobed write, WIDTH/DEPTH parameters; the FSM, counters and handshakes live in burst_memory.

Verification
REQ-021 Write addr=4, len=3, data 0x1111..0x4444, wstrb=2'b11; then read addr=4, len=3 with rready_i=1 -> rdata 0x1111,0x2222,0x3333,0x4444 on consecutive cycles, rlast_o on 4th, done_o one pulse after write, err_o=0.
REQ-022 Write 0xABCD to addr=10 with wstrb=2'b01 over prior value 0x1234 -> read returns 0x12CD.
REQ-023 Read len=1 with rready_i toggling 0,1,0,1 -> each beat held stable until accepted; exactly 2 beats returned.
REQ-024 DEPTH=500, write addr=498, len=3 -> addresses 498,499 written, 500,501 discarded, done_o with err_o=1.
REQ-025 Assert rst_i during beat 2 of a 4-beat write -> outputs zero immediately, beats 3-4 not written, beats 1-2 retained, ready_o=1 first edge after release.
REQ-026 valid_i held high through a busy read -> second command accepted only on the cycle ready_o returns to 1.

Source files
------------

// File: rtl/burst_memory_pkg.sv
// rtl/burst_memory_pkg.sv - shared state encoding and opcode constants for burst_memory
package burst_memory_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/burst_memory_array.sv
// rtl/burst_memory_array.sv - byte-strobed word storage with registered read port
module burst_memory_array #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH/8-1:0]    wstrb,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    // Contents are deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we && in_range(waddr)) begin
            for (int k = 0; k < WIDTH / 8; k++) begin
                if (wstrb[k]) begin
                    mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    // Holding re low keeps the presented word stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= in_range(raddr) ? mem[raddr] : '0;
        end
    end

endmodule

// File: rtl/burst_memory.sv
// rtl/burst_memory.sv - burst command FSM with write/read beat handshakes over burst_memory_array
module burst_memory
    import burst_memory_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  wr_rd_en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [WIDTH/8-1:0]    wstrb_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic                  rlast_o,
    output logic                  done_o,
    output logic                  err_o
);

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n, addr_inc;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_n;
    logic                  err_acc_q, err_acc_n;
    logic                  ready_n, wready_n, rvalid_n, rlast_n, done_n, err_n;
    logic                  mem_we, mem_re;
    logic [ADDR_WIDTH-1:0] mem_raddr;

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a) >= DEPTH;
    endfunction

    assign addr_inc = addr_q + 1'b1;

    always_comb begin
        state_n   = state;
        addr_n    = addr_q;
        cnt_n     = cnt_q;
        err_acc_n = err_acc_q;
        ready_n   = 1'b0;
        wready_n  = 1'b0;
        rvalid_n  = 1'b0;
        rlast_n   = 1'b0;
        done_n    = 1'b0;
        err_n     = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_raddr = addr_q;
        case (state)
            IDLE: begin
                ready_n = 1'b1;
                if (valid_i && ready_o) begin
                    ready_n   = 1'b0;
                    addr_n    = addr_i;
                    cnt_n     = len_i;
                    err_acc_n = out_of_range(addr_i);
                    if (wr_rd_en_i == OP_WRITE) begin
                        state_n  = WRITE;
                        wready_n = 1'b1;
                    end else begin
                        // First word is fetched on the accept edge so it appears next cycle.
                        state_n   = READ;
                        rvalid_n  = 1'b1;
                        rlast_n   = (len_i == '0);
                        err_n     = (len_i == '0) && out_of_range(addr_i);
                        mem_re    = 1'b1;
                        mem_raddr = addr_i;
                    end
                end
            end
            WRITE: begin
                wready_n = 1'b1;
                if (wvalid_i) begin
                    mem_we = 1'b1;
                    if (cnt_q == '0) begin
                        state_n  = IDLE;
                        wready_n = 1'b0;
                        ready_n  = 1'b1;
                        done_n   = 1'b1;
                        err_n    = err_acc_q || out_of_range(addr_q);
                    end else begin
                        addr_n    = addr_inc;
                        cnt_n     = cnt_q - 1'b1;
                        err_acc_n = err_acc_q || out_of_range(addr_q);
                    end
                end
            end
            READ: begin
                rvalid_n = 1'b1;
                rlast_n  = rlast_o;
                err_n    = err_o;
                if (rready_i) begin
                    if (rlast_o) begin
                        state_n  = IDLE;
                        rvalid_n = 1'b0;
                        rlast_n  = 1'b0;
                        err_n    = 1'b0;
                        ready_n  = 1'b1;
                    end else begin
                        addr_n    = addr_inc;
                        cnt_n     = cnt_q - 1'b1;
                        mem_re    = 1'b1;
                        mem_raddr = addr_inc;
                        err_acc_n = err_acc_q || out_of_range(addr_inc);
                        rlast_n   = (cnt_q == LEN_WIDTH'(1));
                        err_n     = (cnt_q == LEN_WIDTH'(1)) && (err_acc_q || out_of_range(addr_inc));
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            err_acc_q <= 1'b0;
            ready_o   <= 1'b0;
            wready_o  <= 1'b0;
            rvalid_o  <= 1'b0;
            rlast_o   <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            state     <= state_n;
            addr_q    <= addr_n;
            cnt_q     <= cnt_n;
            err_acc_q <= err_acc_n;
            ready_o   <= ready_n;
            wready_o  <= wready_n;
            rvalid_o  <= rvalid_n;
            rlast_o   <= rlast_n;
            done_o    <= done_n;
            err_o     <= err_n;
        end
    end

    burst_memory_array #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk_i),
        .rst   (rst_i),
        .we    (mem_we),
        .waddr (addr_q),
        .wdata (wdata_i),
        .wstrb (wstrb_i),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (rdata_o)
    );

endmodule

// File: tb/tb_burst_memory.sv
// tb/tb_burst_memory.sv - randomized self-checking bench for burst_memory against a word-array model
module tb_burst_memory;

    localparam int WIDTH = 16;
    localparam int DEPTH = 500;
    localparam int AW    = 9;
    localparam int LW    = 4;
    localparam int SPAN  = 512;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             valid = 1'b0, wr_rd_en = 1'b0, wvalid = 1'b0, rready = 1'b0;
    logic [AW-1:0]    addr = '0;
    logic [LW-1:0]    len = '0;
    logic [WIDTH-1:0] wdata = '0;
    logic [1:0]       wstrb = '0;
    logic             ready, wready, rvalid, rlast, done, err;
    logic [WIDTH-1:0] rdata;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
        logic             err;
    } rbeat_t;

    logic [WIDTH-1:0] model_mem [SPAN];
    rbeat_t           rd_q[$];
    logic             wr_q[$];
    logic [WIDTH-1:0] got_q[$];
    logic [WIDTH-1:0] wd_q[$];
    logic [1:0]       ws_q[$];
    logic             last_err;

    always #5 clk = ~clk;

    burst_memory #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready),
        .wr_rd_en_i(wr_rd_en), .addr_i(addr), .len_i(len),
        .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
        .rdata_o(rdata), .rvalid_o(rvalid), .rready_i(rready), .rlast_o(rlast),
        .done_o(done), .err_o(err)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic burst_err(input int a, input int l);
        logic any = 1'b0;
        for (int i = 0; i <= l; i++) if ((a + i) % SPAN >= DEPTH) any = 1'b1;
        return any;
    endfunction

    function automatic void push_read(input int a, input int l);
        logic e = burst_err(a, l);
        for (int i = 0; i <= l; i++) begin
            int ad = (a + i) % SPAN;
            rd_q.push_back('{(ad >= DEPTH) ? '0 : model_mem[ad], i == l, (i == l) && e});
        end
    endfunction

    // Every cycle: presented read beats, write completions and idle err level.
    always @(negedge clk) begin
        if (!rst) begin
            if (rvalid) begin
                check("beat_expected", 32'(rd_q.size() != 0), 1);
                if (rd_q.size() != 0) begin
                    check("rdata", 32'(rdata), 32'(rd_q[0].data));
                    check("rlast", 32'(rlast), 32'(rd_q[0].last));
                    check("read_err", 32'(err), 32'(rd_q[0].err));
                    if (rready) void'(rd_q.pop_front());
                end
            end else begin
                check("rlast_without_rvalid", 32'(rlast), 0);
            end
            if (done) begin
                check("done_expected", 32'(wr_q.size() != 0), 1);
                if (wr_q.size() != 0) check("write_err", 32'(err), 32'(wr_q.pop_front()));
            end
            if (!rvalid && !done) check("err_idle", 32'(err), 0);
        end
    end

    task automatic issue(input logic wr, input int a, input int l, input bit keep);
        int t = 0;
        valid = 1'b1; wr_rd_en = wr; addr = AW'(a); len = LW'(l);
        while (!ready && t < 200) begin @(posedge clk); #1; t++; end
        check("accept_in_time", 32'(t < 200), 1);
        if (wr) wr_q.push_back(burst_err(a, l)); else push_read(a, l);
        @(posedge clk); #1;
        if (!keep) valid = 1'b0;
        if (wr) check("wready_after_accept", 32'(wready), 1);
        else    check("rvalid_one_cycle_after_accept", 32'(rvalid), 1);
        check("ready_low_while_busy", 32'(ready), 0);
    endtask

    task automatic wbeat(input int ad, input logic [WIDTH-1:0] d, input logic [1:0] s);
        wvalid = 1'b1; wdata = d; wstrb = s;
        check("wready_beat", 32'(wready), 1);
        @(posedge clk); #1;
        if (ad < DEPTH) for (int k = 0; k < 2; k++) if (s[k]) model_mem[ad][8*k +: 8] = d[8*k +: 8];
        wvalid = 1'b0;
    endtask

    task automatic write_burst(input int a, input int l, input bit gaps);
        issue(1'b1, a, l, 1'b0);
        for (int i = 0; i <= l; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if (wd_q.size() != 0) wbeat((a + i) % SPAN, wd_q.pop_front(), ws_q.pop_front());
            else                  wbeat((a + i) % SPAN, WIDTH'($urandom), 2'($urandom));
        end
        check("done_pulse", 32'(done), 1);
        check("wready_end", 32'(wready), 0);
        check("ready_end_write", 32'(ready), 1);
        last_err = err;
    endtask

    task automatic consume(input int l, input int mode);
        int beats = 0;
        int cyc = 0;
        logic pend = 1'b0;
        logic [WIDTH-1:0] held = '0;
        got_q.delete();
        while (beats <= l && cyc < 100) begin
            if (pend) check("rdata_stable", 32'(rdata), 32'(held));
            pend = 1'b0;
            if (rvalid && rready) begin got_q.push_back(rdata); beats++; end
            else if (rvalid) begin pend = 1'b1; held = rdata; end
            @(posedge clk); #1; cyc++;
            case (mode)
                0: rready = 1'b1;
                1: rready = 1'($urandom);
                default: rready = ~rready;
            endcase
        end
        check("read_beats", 32'(beats), 32'(l + 1));
        if (mode == 0) check("read_throughput", 32'(cyc), 32'(l + 1));
        check("rvalid_end", 32'(rvalid), 0);
        check("ready_end_read", 32'(ready), 1);
        rready = 1'b0;
    endtask

    task automatic read_burst(input int a, input int l, input int mode);
        rready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom) : 1'b0;
        issue(1'b0, a, l, 1'b0);
        consume(l, mode);
    endtask

    initial begin
        for (int i = 0; i < SPAN; i++) model_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(ready), 0);
        check("reset_rvalid", 32'(rvalid), 0);
        check("reset_rdata", 32'(rdata), 0);
        rst = 1'b0;
        check("ready_before_first_edge", 32'(ready), 0);
        @(posedge clk); #1;
        check("ready_first_edge", 32'(ready), 1);

        for (int b = 0; b < SPAN; b += 16) begin
            for (int i = 0; i < 16; i++) begin wd_q.push_back(WIDTH'($urandom)); ws_q.push_back(2'b11); end
            write_burst(b, 15, 1'b0);
            check("init_err", 32'(last_err), 32'(b + 15 >= DEPTH));
        end

        wd_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        ws_q = '{2'b11, 2'b11, 2'b11, 2'b11};
        write_burst(4, 3, 1'b0);
        check("basic_write_err", 32'(last_err), 0);
        read_burst(4, 3, 0);
        check("basic_rd0", 32'(got_q[0]), 32'h1111);
        check("basic_rd1", 32'(got_q[1]), 32'h2222);
        check("basic_rd2", 32'(got_q[2]), 32'h3333);
        check("basic_rd3", 32'(got_q[3]), 32'h4444);

        wd_q = '{16'h1234, 16'hABCD};
        ws_q = '{2'b11, 2'b01};
        write_burst(10, 0, 1'b0);
        write_burst(10, 0, 1'b0);
        read_burst(10, 0, 0);
        check("strobe_merge", 32'(got_q[0]), 32'h12CD);

        read_burst(100, 1, 2);
        check("toggle_beat_count", 32'(got_q.size()), 2);
        rready = 1'b1;
        repeat (3) begin @(posedge clk); #1; check("no_extra_beat", 32'(rvalid), 0); end
        rready = 1'b0;

        wd_q = '{16'h5001, 16'h5002, 16'h5003, 16'h5004};
        ws_q = '{2'b11, 2'b11, 2'b11, 2'b11};
        write_burst(498, 3, 1'b0);
        check("top_write_err", 32'(last_err), 1);
        read_burst(498, 3, 0);
        check("top_rd0", 32'(got_q[0]), 32'h5001);
        check("top_rd1", 32'(got_q[1]), 32'h5002);
        check("top_rd2_discarded", 32'(got_q[2]), 0);
        check("top_rd3_discarded", 32'(got_q[3]), 0);

        wd_q = '{16'h6001, 16'h6002, 16'h6003, 16'h6004};
        ws_q = '{2'b11, 2'b11, 2'b11, 2'b11};
        write_burst(510, 3, 1'b0);
        read_burst(0, 1, 0);
        check("wrap_rd0", 32'(got_q[0]), 32'h6003);
        check("wrap_rd1", 32'(got_q[1]), 32'h6004);

        issue(1'b1, 20, 3, 1'b0);
        wbeat(20, 16'hA001, 2'b11);
        wbeat(21, 16'hA002, 2'b11);
        wvalid = 1'b1; wdata = 16'hA003; wstrb = 2'b11;
        rst = 1'b1;
        #1;
        check("abort_ready", 32'(ready), 0);
        check("abort_wready", 32'(wready), 0);
        check("abort_done_err", 32'({done, err, rvalid, rlast}), 0);
        check("abort_rdata", 32'(rdata), 0);
        wr_q.delete();
        rd_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; wvalid = 1'b0;
        check("abort_ready_before_edge", 32'(ready), 0);
        @(posedge clk); #1;
        check("abort_ready_first_edge", 32'(ready), 1);
        read_burst(20, 3, 0);
        check("abort_kept0", 32'(got_q[0]), 32'hA001);
        check("abort_kept1", 32'(got_q[1]), 32'hA002);

        rready = 1'b1;
        issue(1'b0, 40, 2, 1'b1);
        addr = AW'(60); len = LW'(1); wr_rd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("busy_ready", 32'(ready), 32'(i == 3));
            if (i < 3) begin @(posedge clk); #1; end
        end
        push_read(60, 1);
        @(posedge clk); #1;
        valid = 1'b0;
        check("second_cmd_first_beat", 32'(rvalid), 1);
        consume(1, 0);

        for (int n = 0; n < 60; n++) begin
            int a = $urandom_range(0, SPAN - 1);
            int l = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) write_burst(a, l, 1'b1);
            else                           read_burst(a, l, $urandom_range(0, 2));
        end

        repeat (4) @(posedge clk);
        #1;
        check("reads_drained", 32'(rd_q.size()), 0);
        check("writes_drained", 32'(wr_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
